// File: rtl/seq_mult_shift_add_if.sv
// Request/response bundle for the shift-and-add multiplier: operands and start
// travel in from the ALU side; busy, done and product travel back.
interface seq_mult_shift_add_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one ripple-carry add plus a
// right shift of {C,A,Q} per cycle, WIDTH steps, then a one-cycle done pulse.
module seq_mult_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
    assign carry[i + 1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
  end

  assign cout_o = carry[WIDTH];
endmodule

module seq_mult_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_mult_shift_add_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               c_q, c_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   a_add;
  logic               c_add;
  logic [WIDTH-1:0]   a_step;
  logic [WIDTH-1:0]   q_step;

  // C is emptied by every shift, so feeding it as carry-in adds nothing.
  seq_mult_rca #(.WIDTH(WIDTH)) u_rca (
    .x_i    (a_q),
    .y_i    (m_q),
    .cin_i  (c_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign a_add  = q_q[0] ? add_sum  : a_q;
  assign c_add  = q_q[0] ? add_cout : 1'b0;
  assign a_step = {c_add, a_add[WIDTH-1:1]};
  assign q_step = {a_add[0], q_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every target gets its hold value first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          m_d     = bus.a;
          q_d     = bus.b;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_step;
        q_d   = q_step;
        c_d   = 1'b0;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = {a_step, q_step};
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is reset so an aborted multiply leaves no residue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking so all registers see pre-edge values of each other.
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed and swept checks of the 8-bit shift-and-add multiplier: latency,
// done/busy framing, ignored starts, mid-run reset and back-to-back operation.
module tb_seq_mult_shift_add;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] prev_product;

  seq_mult_shift_add_if #(.WIDTH(8)) bus ();

  seq_mult_shift_add #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One multiply with full framing checks; inject pulses start with other operands in RUN and DONE.
  task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp, input bit inject);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_done_early"}, 32'(bus.done), 32'd0);
      if (k == 4) check({tag, "_hold"}, 32'(bus.product), 32'(prev_product));
      if (inject && k == 3) begin
        bus.start = 1'b1;
        bus.a     = ~av;
        bus.b     = ~bv;
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
    check({tag, "_product"}, 32'(bus.product), 32'(exp));
    if (inject) begin
      bus.start = 1'b1;
      bus.a     = 8'h5A;
      bus.b     = 8'hA5;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_done_once"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    check({tag, "_product_held"}, 32'(bus.product), 32'(exp));
    prev_product = exp;
  endtask

  task automatic mid_run_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h95;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_in_run", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_product = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
      check("abort_no_busy", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic back_to_back();
    logic [7:0]  va [4] = '{8'h12, 8'hFF, 8'h01, 8'hD2};
    logic [7:0]  vb [4] = '{8'h95, 8'hFF, 8'hFF, 8'h95};
    logic [15:0] vp [4] = '{16'h0A7A, 16'hFE01, 16'h00FF, 16'h7A3A};
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = va[0];
    bus.b     = vb[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) begin
        bus.a = va[i + 1];
        bus.b = vb[i + 1];
      end else begin
        bus.start = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.done) begin
          got = 1'b1;
          check("b2b_latency", 32'(k), 32'd8);
          check("b2b_product", 32'(bus.product), 32'(vp[i]));
          break;
        end
      end
      if (!got) check("b2b_done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("b2b_idle", 32'(bus.busy), 32'd0);
    end
    prev_product = vp[3];
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_checks     = 0;
    n_fail       = 0;
    prev_product = 16'h0000;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;

    run_mult("m12x95", 8'h12, 8'h95, 16'h0A7A, 1'b0);
    run_mult("mFFxFF", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run_mult("m01xFF", 8'h01, 8'hFF, 16'h00FF, 1'b0);
    run_mult("mD2x95", 8'hD2, 8'h95, 16'h7A3A, 1'b0);
    run_mult("m00xB7", 8'h00, 8'hB7, 16'h0000, 1'b0);
    run_mult("inject", 8'h12, 8'h95, 16'h0A7A, 1'b1);
    mid_run_reset();
    run_mult("after_abort", 8'h12, 8'h95, 16'h0A7A, 1'b0);
    back_to_back();

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mult("sweep", ra, rb, {8'h00, ra} * {8'h00, rb}, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
- Sequential unsigned WIDTH x WIDTH multiplier using the shift-and-add algorithm.
- Consumes one WIDTH-bit add with carry-out per cycle, i.e. the sum/cout of a ripple-carry adder stage, which it instantiates internally; it is the stage directly downstream of that adder.
- Operands are accepted on a start pulse; a 2*WIDTH-bit product is returned with a one-cycle done pulse.
- Sits in the lab ALU datapath next to the existing 8-bit adder.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits. Must be at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to start a multiply; sampled only in IDLE.
- a  input  WIDTH  multiplicand, unsigned; captured on an accepted start.
- b  input  WIDTH  multiplier, unsigned; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  registered result; holds its value until the next completion.

Behaviour:
- One clock; rst is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, product=0, all internal registers (M, A, Q, C, cnt)=0.
- Internal registers:
  - M: WIDTH bits, multiplicand.
  - A: WIDTH bits, accumulator high half.
  - Q: WIDTH bits, multiplier / low half.
  - C: 1 bit, adder carry.
  - cnt: ceil(log2(WIDTH+1)) bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: M<=a, Q<=b, A<=0, C<=0, cnt<=WIDTH, go to RUN.
  - Otherwise remain in IDLE.
  - a and b are don't-care when start=0.
- RUN, each edge is one step:
  - {C,A} = Q[0] ? A+M (WIDTH-bit add, carry-out into C) : {0,A}.
  - Then shift right: {C,A,Q} <= {0,C,A,Q} >> 1, i.e. A<= {C_new, A_new[WIDTH-1:1]}, Q<= {A_new[0], Q[WIDTH-1:1]}.
  - cnt<=cnt-1.
  - The add and shift happen in the same edge; no separate add cycle.
  - On the step where cnt==1: product<={A_next,Q_next}, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Start accepted at edge 0 leads to exactly WIDTH RUN cycles.
  - done is high during the cycle following edge WIDTH; product is valid at that same edge.
  - Next start is accepted at the earliest edge WIDTH+2.
  - Throughput: one result per WIDTH+2 cycles.
- busy=1 only in RUN; done=1 only in DONE; never both high at once.
- start while in RUN or DONE: ignored, no queuing. a and b changes during RUN have no effect.
- start held continuously high: a new multiply begins at each return to IDLE.
- product is not modified during RUN; it holds the previous result until the DONE transition.
- Width rules:
  - Arithmetic is unsigned; the carry out of the WIDTH-bit add is never lost (kept in C).
  - Max result (2^WIDTH-1)^2 fits in 2*WIDTH bits; no overflow flag.
- Zero operands take the same WIDTH-cycle latency; there is no early termination.
- rst asserted mid-RUN or in DONE: immediate return to reset values, with product cleared to 0. No done pulse for the aborted operation.

Test Plan:
- Reset, then start with a=0x12, b=0x95 -> busy high for 8 cycles, done pulse 9 cycles after the start edge, product=0x0A7A.
- a=0xFF, b=0xFF (worst-case carries) -> product=0xFE01. a=0x01, b=0xFF -> product=0x00FF. a=0xD2, b=0x95 -> product=0x7A3A.
- a=0x00, b=0xB7 -> full 8-cycle latency, product=0x0000, done pulses once.
- Pulse start again with different a and b during RUN and during DONE -> ignored; result matches the original operands; busy/done timing unchanged.
- Assert rst in the 4th RUN cycle -> busy, done and product are 0 immediately with no clock; no done follows. A new start afterwards with 0x12*0x95 gives 0x0A7A.
- start held high across back-to-back operations with changing a and b -> done every 10 cycles, each product correct. Also a random 1000-pair sweep checked against a*b.
